// File: rtl/muldiv_sequencer_pkg.sv
// Shared constants and state encoding for the iterative signed multiply/divide sequencer.
package muldiv_sequencer_pkg;
  localparam int DATA_W = 32;
  localparam int ITER_N = 32;
  localparam int CNT_W  = 6;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MULT = 3'd1,
    S_DIV  = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4,
    S_DZ   = 3'd5
  } state_t;
endpackage

// File: rtl/muldiv_iter_counter.sv
// Loadable 6-bit down counter; last flags the final iteration (count == 1).
module muldiv_iter_counter
  import muldiv_sequencer_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             dec,
  input  logic [CNT_W-1:0] load_val,
  output logic             last
);
  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - CNT_W'(1);
    end
  end

  assign last = (count == CNT_W'(1));
endmodule

// File: rtl/muldiv_sequencer.sv
// Sequential signed 32x32 multiply and 32/32 divide on operand magnitudes,
// with a single sign-fix cycle before results are published on Hi/Lo.
module muldiv_sequencer
  import muldiv_sequencer_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              mult,
  input  logic              div,
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  output logic [DATA_W-1:0] Hi,
  output logic [DATA_W-1:0] Lo,
  output logic              busy,
  output logic              done,
  output logic              dzero
);
  state_t                  state;
  logic [2*DATA_W-1:0]     acc;
  logic [DATA_W-1:0]       mcand;
  logic                    sign_a, sign_b;
  logic                    start_mul, start_div, start_dz, iter_last;
  logic [DATA_W:0]         mul_sum;
  logic [2*DATA_W-1:0]     mul_next, div_next, prod_fix;
  logic                    div_ge;
  logic [DATA_W-1:0]       div_rem, fix_hi, fix_lo;
  logic                    op_mul;

  function automatic logic [DATA_W-1:0] mag(input logic signed [DATA_W-1:0] x);
    return x[DATA_W-1] ? $unsigned(-x) : $unsigned(x);
  endfunction

  assign start_mul = (state == S_IDLE) && mult;
  assign start_div = (state == S_IDLE) && div && !mult && (B != '0);
  assign start_dz  = (state == S_IDLE) && div && !mult && (B == '0);

  muldiv_iter_counter u_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (start_mul || start_div),
    .dec      ((state == S_MULT) || (state == S_DIV)),
    .load_val (CNT_W'(ITER_N)),
    .last     (iter_last)
  );

  // Shift-add: conditionally add multiplicand to the upper half, then shift right.
  assign mul_sum  = {1'b0, acc[2*DATA_W-1:DATA_W]} + (acc[0] ? {1'b0, mcand} : '0);
  assign mul_next = {mul_sum, acc[DATA_W-1:1]};

  // Restoring division: {rem, quotient} shifts left, quotient bit set when trial fits.
  assign div_ge   = (acc[2*DATA_W-1:DATA_W-1] >= {1'b0, mcand});
  assign div_rem  = acc[2*DATA_W-2:DATA_W-1] - mcand;
  assign div_next = div_ge ? {div_rem, acc[DATA_W-2:0], 1'b1} : {acc[2*DATA_W-2:0], 1'b0};

  assign prod_fix = (sign_a ^ sign_b) ? (~acc + 64'd1) : acc;
  assign fix_hi   = op_mul ? prod_fix[2*DATA_W-1:DATA_W]
                           : (sign_a ? (~acc[2*DATA_W-1:DATA_W] + 32'd1) : acc[2*DATA_W-1:DATA_W]);
  assign fix_lo   = op_mul ? prod_fix[DATA_W-1:0]
                           : ((sign_a ^ sign_b) ? (~acc[DATA_W-1:0] + 32'd1) : acc[DATA_W-1:0]);

  // Operand capture and iteration datapath
  always_ff @(posedge clk) begin
    if (start_mul || start_div) begin
      op_mul <= start_mul;
      sign_a <= A[DATA_W-1];
      sign_b <= B[DATA_W-1];
      mcand  <= start_mul ? mag(A) : mag(B);
      acc    <= {{DATA_W{1'b0}}, (start_mul ? mag(B) : mag(A))};
    end else if (state == S_MULT) begin
      acc <= mul_next;
    end else if (state == S_DIV) begin
      acc <= div_next;
    end
  end

  // Control FSM with registered flags and result registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      dzero <= 1'b0;
      Hi    <= '0;
      Lo    <= '0;
    end else begin
      done  <= 1'b0;
      dzero <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start_mul) begin
            state <= S_MULT;
            busy  <= 1'b1;
          end else if (start_div) begin
            state <= S_DIV;
            busy  <= 1'b1;
          end else if (start_dz) begin
            state <= S_DZ;
            busy  <= 1'b1;
            dzero <= 1'b1;
          end
        end
        S_MULT, S_DIV: begin
          if (iter_last) state <= S_FIX;
        end
        S_FIX: begin
          Hi    <= fix_hi;
          Lo    <= fix_lo;
          done  <= 1'b1;
          state <= S_DONE;
        end
        S_DONE, S_DZ: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Randomized and directed bench for muldiv_sequencer against a plain-arithmetic reference.
module tb_muldiv_sequencer;
  logic        clk = 1'b0;
  logic        reset;
  logic        mult, div;
  logic [31:0] A, B, Hi, Lo;
  logic        busy, done, dzero;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_hi  = '0;
  logic [31:0] exp_lo  = '0;

  always #5 clk = ~clk;

  muldiv_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .mult  (mult),
    .div   (div),
    .A     (A),
    .B     (B),
    .Hi    (Hi),
    .Lo    (Lo),
    .busy  (busy),
    .done  (done),
    .dzero (dzero)
  );

  function automatic void model(input bit m, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] hi, output logic [31:0] lo);
    longint sa, sb, p, q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (m) begin
      p  = sa * sb;
      hi = p[63:32];
      lo = p[31:0];
    end else begin
      q  = sa / sb;
      r  = sa % sb;
      hi = r[31:0];
      lo = q[31:0];
    end
  endfunction

  // Caller must be at a negedge; inputs are applied for the next rising edge.
  task automatic do_op(input bit m, input bit d, input logic [31:0] a, input logic [31:0] b,
                       input bit interfere, input string name);
    logic [31:0] eh, el;
    int          cyc;
    bit          seen, dz_seen;
    model(m, a, b, eh, el);
    n_tests++;
    if (Hi !== exp_hi || Lo !== exp_lo) begin
      n_fail++;
      $display("FAIL %s hold: Hi=%h Lo=%h expected Hi=%h Lo=%h", name, Hi, Lo, exp_hi, exp_lo);
    end
    mult = m; div = d; A = a; B = b;
    @(negedge clk);
    mult = 1'b0; div = 1'b0; A = $urandom; B = $urandom;
    cyc = 1;
    n_tests++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL %s busy_start: busy=%b expected 1", name, busy);
    end
    seen = 0; dz_seen = 0;
    while (cyc <= 40 && !seen) begin
      if (done === 1'b1) seen = 1;
      else begin
        if (dzero === 1'b1) dz_seen = 1;
        if (interfere && cyc == 5) begin
          mult = 1'b1; div = 1'b1; A = $urandom; B = '0;
        end else begin
          mult = 1'b0; div = 1'b0;
        end
        @(negedge clk);
        cyc++;
      end
    end
    n_tests++;
    if (!seen || cyc != 34 || dz_seen) begin
      n_fail++;
      $display("FAIL %s latency: done_cycle=%0d seen=%b dzero_seen=%b expected cycle 34", name, cyc, seen, dz_seen);
    end
    n_tests++;
    if (Hi !== eh || Lo !== el) begin
      n_fail++;
      $display("FAIL %s result: A=%h B=%h Hi=%h Lo=%h expected Hi=%h Lo=%h", name, a, b, Hi, Lo, eh, el);
    end
    exp_hi = eh; exp_lo = el;
    @(negedge clk);
    n_tests++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s done_pulse: done=%b busy=%b expected 0 0", name, done, busy);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; mult = 1'b0; div = 1'b0; A = '0; B = '0;
    #12;
    n_tests++;
    if (Hi !== 32'h0 || Lo !== 32'h0 || busy !== 1'b0 || done !== 1'b0 || dzero !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: Hi=%h Lo=%h busy=%b done=%b dzero=%b expected all 0", Hi, Lo, busy, done, dzero);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed();
    do_op(1, 0, 32'h00000007, 32'hFFFFFFFD, 0, "mul_7_m3");
    do_op(0, 1, 32'hFFFFFFF9, 32'h00000002, 0, "div_m7_2");
    do_op(0, 1, 32'h80000000, 32'hFFFFFFFF, 1, "div_min_m1_ignore");
    do_op(1, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, "mul_m1_m1");
    do_op(1, 1, 32'h00001234, 32'hFFFF0003, 0, "mul_div_both");
  endtask

  task automatic test_dzero();
    bit bad_done;
    mult = 1'b0; div = 1'b1; A = 32'd5; B = '0;
    @(negedge clk);
    div = 1'b0;
    n_tests++;
    if (dzero !== 1'b1 || busy !== 1'b1 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL dzero_pulse: dzero=%b busy=%b done=%b expected 1 1 0", dzero, busy, done);
    end
    @(negedge clk);
    n_tests++;
    if (dzero !== 1'b0 || busy !== 1'b0 || Hi !== exp_hi || Lo !== exp_lo) begin
      n_fail++;
      $display("FAIL dzero_after: dzero=%b busy=%b Hi=%h Lo=%h expected 0 0 Hi=%h Lo=%h",
               dzero, busy, Hi, Lo, exp_hi, exp_lo);
    end
    bad_done = 0;
    for (int i = 0; i < 5; i++) begin
      if (done !== 1'b0 || dzero !== 1'b0) bad_done = 1;
      @(negedge clk);
    end
    n_tests++;
    if (bad_done) begin
      n_fail++;
      $display("FAIL dzero_quiet: done or dzero pulsed after divide by zero, expected none");
    end
  endtask

  task automatic test_random(input int n);
    logic [31:0] edge_v[6];
    logic [31:0] a, b;
    bit          m;
    edge_v = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'h80000001};
    for (int i = 0; i < n; i++) begin
      m = $urandom_range(0, 1);
      a = ($urandom_range(0, 3) == 0) ? edge_v[$urandom_range(0, 5)] : $urandom;
      b = ($urandom_range(0, 3) == 0) ? edge_v[$urandom_range(0, 5)] : $urandom;
      if (!m && b == '0) b = 32'd3;
      do_op(m, !m, a, b, (i % 3) == 0, m ? "rand_mul" : "rand_div");
    end
  endtask

  task automatic test_reset_mid();
    mult = 1'b1; div = 1'b0; A = 32'h00012345; B = 32'h00000077;
    @(negedge clk);
    mult = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b0;
    #1;
    n_tests++;
    if (busy !== 1'b0 || Hi !== 32'h0 || Lo !== 32'h0 || done !== 1'b0 || dzero !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid: busy=%b Hi=%h Lo=%h done=%b dzero=%b expected all 0", busy, Hi, Lo, done, dzero);
    end
    exp_hi = '0; exp_lo = '0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_tests++;
    if (busy !== 1'b0 || done !== 1'b0 || dzero !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: busy=%b done=%b dzero=%b expected 0 0 0", busy, done, dzero);
    end
    do_op(1, 0, 32'd3, 32'd4, 0, "mul_3_4_after_reset");
  endtask

  task automatic test_back_to_back();
    do_op(0, 1, 32'h0000_0064, 32'hFFFF_FFF9, 0, "b2b_div");
    do_op(1, 0, 32'h8000_0000, 32'h8000_0000, 0, "b2b_mul");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_dzero();
    test_random(12);
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
